// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_unit
// Brief    : Next-PC selection with halt/resume, misaligned-target trap and
//            retired-instruction counter.
// Revision : 1.0  initial release
// ============================================================================
module pc_next_unit #(
    parameter int             N        = 32,
    parameter logic [N-1:0]   RESET_PC = '0,
    parameter logic [N-1:0]   TRAP_VEC = 'h100
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         stall,
    input  wire logic         branch_taken,
    input  wire logic         jump,
    input  wire logic         halt,
    input  wire logic         resume,
    input  wire logic [N-1:0] shifted_offset,
    input  wire logic [N-1:0] jalr_target,
    output logic [N-1:0]      pc,
    output logic [N-1:0]      pc_plus4,
    output logic [N-1:0]      branch_target,
    output logic              misaligned,
    output logic [1:0]        state,
    output logic [N-1:0]      instret
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_TRAP   = 2'd2,
        S_BAD    = 2'd3
    } state_t;

    localparam logic [N-1:0] C_FOUR = N'(4);
    localparam logic [N-1:0] C_ONE  = N'(1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_pc;
    logic [N-1:0] w_pc_nxt;
    logic [N-1:0] r_instret;
    logic [N-1:0] w_instret_nxt;
    logic         r_misaligned;
    logic         w_misaligned_nxt;
    logic [N-1:0] w_pc_plus4;
    logic [N-1:0] w_branch_target;
    logic [N-1:0] w_candidate;

    assign w_pc_plus4      = r_pc + C_FOUR;
    assign w_branch_target = r_pc + shifted_offset;

    always_comb begin
        w_candidate = w_pc_plus4;
        if (jump) begin
            w_candidate = jalr_target & ~C_ONE;
        end else if (branch_taken) begin
            w_candidate = w_branch_target;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_instret_nxt    = r_instret;
        w_misaligned_nxt = 1'b0;
        case (r_state)
            S_RUN: begin
                if (!stall) begin
                    if (halt) begin
                        w_state_nxt = S_HALTED;
                    // Any low-order bit set means the target is not word aligned.
                    end else if (w_candidate[1:0] != 2'b00) begin
                        w_pc_nxt         = TRAP_VEC;
                        w_state_nxt      = S_TRAP;
                        w_misaligned_nxt = 1'b1;
                    end else begin
                        w_pc_nxt      = w_candidate;
                        w_instret_nxt = r_instret + C_ONE;
                    end
                end
            end
            S_HALTED: begin
                if (resume) begin
                    w_pc_nxt      = w_pc_plus4;
                    w_instret_nxt = r_instret + C_ONE;
                    w_state_nxt   = S_RUN;
                end
            end
            default: begin
                // TRAP already holds TRAP_VEC; the illegal encoding recovers likewise.
                w_state_nxt = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_pc         <= RESET_PC;
            r_instret    <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_instret    <= w_instret_nxt;
            r_misaligned <= w_misaligned_nxt;
        end
    end

    assign pc            = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign branch_target = w_branch_target;
    assign misaligned    = r_misaligned;
    assign state         = r_state;
    assign instret       = r_instret;

endmodule
`default_nettype wire
